// File: rtl/periph_reset_seq.sv
// Staged peripheral reset release sequencer with a 3-register CSR window.
// Optional macro PERIPH_RESET_SEQ_ORDERED_ABORT_EN: abort re-asserts stages one by one in reverse.
module periph_reset_seq #(
  parameter logic [4:0] BASE_ADDR  = 5'h1d,
  parameter int         NUM_STAGES = 4,
  parameter logic [7:0] DFL_DELAY  = 8'h04
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [4:0]            csr_a,
  input  logic [7:0]            csr_di,
  input  logic                  csr_we,
  output logic [7:0]            csr_do,
  input  logic                  start,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [4:0] A_CTRL  = BASE_ADDR;
  localparam logic [4:0] A_DELAY = BASE_ADDR + 5'd1;
  localparam logic [4:0] A_HOLD  = BASE_ADDR + 5'd2;
  localparam logic [2:0] LAST    = 3'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RELEASE,
    S_DONE,
    S_ASSERT
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [NUM_STAGES-1:0]   released_q, released_d;
  logic [NUM_STAGES-1:0]   hold_q, hold_d;
  logic [7:0]              delay_q, delay_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    go;
  logic [7:0]              hold_rd;

  // abort always beats a simultaneous start or restart
  assign go = (start | (csr_we & (csr_a == A_CTRL) & csr_di[0])) & ~abort;

`ifdef PERIPH_RESET_SEQ_ORDERED_ABORT_EN
  logic [2:0] top_idx;
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (released_q[i]) top_idx = 3'(i);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    released_d = released_q;
    hold_d     = hold_q;
    delay_d    = delay_q;
    if (csr_we && csr_a == A_DELAY) delay_d = csr_di;
    if (csr_we && csr_a == A_HOLD)  hold_d  = csr_di[NUM_STAGES-1:0];

    case (state_q)
      S_IDLE: begin
        released_d = '0;
        if (go) begin
          state_d = S_WAIT;
          cnt_d   = delay_q;
          idx_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_RELEASE;
        else if (ce)       cnt_d   = cnt_q - 8'd1;
      end
      S_RELEASE: begin
        released_d = released_q | (ONE << idx_q);
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = delay_q;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (go) begin
          released_d = '0;
          idx_d      = '0;
          cnt_d      = delay_q;
          state_d    = S_WAIT;
        end
      end
      S_ASSERT: begin
`ifdef PERIPH_RESET_SEQ_ORDERED_ABORT_EN
        if (released_q == '0) begin
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          released_d = released_q & ~(ONE << top_idx);
          cnt_d      = delay_q;
        end else if (ce) begin
          cnt_d = cnt_q - 8'd1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
`ifdef PERIPH_RESET_SEQ_ORDERED_ABORT_EN
      // first abort walks stages back down; a second one collapses at once
      if (state_q == S_ASSERT) begin
        state_d    = S_IDLE;
        released_d = '0;
        cnt_d      = '0;
        idx_d      = '0;
      end else if (state_q != S_IDLE) begin
        state_d    = S_ASSERT;
        released_d = released_q;
        cnt_d      = delay_q;
        idx_d      = '0;
      end
`else
      state_d    = S_IDLE;
      released_d = '0;
      cnt_d      = '0;
      idx_d      = '0;
`endif
    end

    busy_d = (state_d == S_WAIT) || (state_d == S_RELEASE) || (state_d == S_ASSERT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      released_q <= '0;
      hold_q     <= '0;
      delay_q    <= DFL_DELAY;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      released_q <= released_d;
      hold_q     <= hold_d;
      delay_q    <= delay_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rst_out = ~released_q | hold_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_comb begin
    hold_rd                   = '0;
    hold_rd[NUM_STAGES-1:0]   = hold_q;
    csr_do                    = 8'h00;
    if (csr_a == A_CTRL)       csr_do = {1'b0, idx_q, 1'b0, done_q, busy_q, 1'b0};
    else if (csr_a == A_DELAY) csr_do = delay_q;
    else if (csr_a == A_HOLD)  csr_do = hold_rd;
  end

endmodule

// File: tb/tb_periph_reset_seq.sv
// Self-checking bench for periph_reset_seq: directed phases then random traffic against a stage-count model.
module tb_periph_reset_seq;

  localparam int         N   = 4;
  localparam logic [4:0] A0  = 5'h1d;
  localparam logic [4:0] A1  = 5'h1e;
  localparam logic [4:0] A2  = 5'h1f;
  localparam logic [4:0] A3  = 5'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic [4:0] csr_a = A0;
  logic [7:0] csr_di = 8'h00;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [N-1:0] rst_out;
  logic       busy;
  logic       done;

  periph_reset_seq #(.BASE_ADDR(A0), .NUM_STAGES(N), .DFL_DELAY(8'h04)) dut (
    .clk(clk), .rst(rst), .ce(ce), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .start(start), .abort(abort), .rst_out(rst_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ce_period = 4;

  // model: m_k stages released (always the low m_k bits); mode 0 idle/done, 1 sequencing, 2 walking back
  int         m_mode = 0;
  int         m_k = 0;
  int         m_ce_left = 0;
  int         m_tail = 0;
  logic [7:0] m_delay = 8'h04;
  logic [3:0] m_hold = 4'h0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_rst();
    int mask;
    mask = (1 << m_k) - 1;
    return ~4'(mask) | m_hold;
  endfunction

  function automatic logic [7:0] exp_read(input logic [4:0] a);
    logic [3:0] idx;
    logic       b, d;
    b   = (m_mode != 0);
    d   = (m_mode == 0) && (m_k == N);
    idx = (m_mode == 1) ? 4'(m_k) : (d ? 4'(N - 1) : 4'd0);
    if (a == A0) return {idx, 1'b0, d, b, 1'b0};
    if (a == A1) return m_delay;
    if (a == A2) return {4'h0, m_hold};
    return 8'h00;
  endfunction

  task automatic model_edge(input logic c, input logic st, input logic ab, input logic we,
                            input logic [4:0] a, input logic [7:0] di);
    logic go;
    go = (st || (we && a == A0 && di[0])) && !ab;
    if (ab) begin
`ifdef PERIPH_RESET_SEQ_ORDERED_ABORT_EN
      if (m_mode == 2) begin
        m_mode = 0; m_k = 0;
      end else if (m_mode == 1 || m_k == N) begin
        m_mode = 2; m_ce_left = int'(m_delay);
      end
`else
      m_mode = 0; m_k = 0;
`endif
    end else if (m_mode == 1) begin
      // each stage: wait DELAY ce ticks, then two more clocks until the bit drops
      if (m_ce_left > 0) begin
        if (c) m_ce_left--;
      end else begin
        m_tail--;
        if (m_tail == 0) begin
          m_k++;
          if (m_k == N) m_mode = 0;
          else begin m_ce_left = int'(m_delay); m_tail = 2; end
        end
      end
    end else if (m_mode == 2) begin
      if (m_k == 0) m_mode = 0;
      else if (m_ce_left == 0) begin m_k--; m_ce_left = int'(m_delay); end
      else if (c) m_ce_left--;
    end else if (go) begin
      m_mode = 1; m_k = 0; m_ce_left = int'(m_delay); m_tail = 2;
    end
    if (we && a == A1) m_delay = di;
    if (we && a == A2) m_hold = di[3:0];
  endtask

  task automatic step(input logic st, input logic ab, input logic we,
                      input logic [4:0] a, input logic [7:0] di);
    logic c;
    c = (ce_period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % ce_period) == 0);
    ce = c; start = st; abort = ab; csr_we = we; csr_a = a; csr_di = di;
    @(posedge clk);
    model_edge(c, st, ab, we, a, di);
    cyc++;
    @(negedge clk);
    ce = 1'b0; start = 1'b0; abort = 1'b0; csr_we = 1'b0;
    chk("rst_out", {4'h0, rst_out}, {4'h0, exp_rst()});
    chk("busy", {7'h0, busy}, {7'h0, m_mode != 0});
    chk("done", {7'h0, done}, {7'h0, (m_mode == 0) && (m_k == N)});
    chk("csr_do", csr_do, exp_read(a));
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(tag, csr_do, exp);
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step(1'b0, 1'b0, 1'b0, A0, 8'h00);
      n++;
    end
    chk(tag, {7'h0, done}, 8'h01);
  endtask

  int   n_rel;
  int   rel_t[4];
  int   n;
  logic [3:0] prev;
  logic [4:0] ra;
  logic [7:0] rd;
  logic st, ab, we;

  initial begin
    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rst_out", {4'h0, rst_out}, 8'h0f);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    chk("rst_done", {7'h0, done}, 8'h00);
    rd_chk("rst_delay", A1, 8'h04);
    rd_chk("rst_hold", A2, 8'h00);
    rd_chk("rst_out_of_window", A3, 8'h00);
    rd_chk("rst_ctrl", A0, 8'h00);
    rd_chk("rst_far_addr", 5'h10, 8'h00);

    // DELAY=2, ce every 4 clocks: stages drop in order, 8-9 clocks apart
    ce_period = 4;
    step(1'b0, 1'b0, 1'b1, A1, 8'h02);
    step(1'b1, 1'b0, 1'b0, A0, 8'h00);
    n_rel = 0;
    prev  = rst_out;
    for (int i = 0; i < 200 && !done; i++) begin
      step(1'b0, 1'b0, 1'b0, A0, 8'h00);
      if (rst_out != prev) begin
        if (n_rel < 4) rel_t[n_rel] = cyc;
        n_rel++;
        prev = rst_out;
      end
    end
    chk("p2_done", {7'h0, done}, 8'h01);
    chk("p2_release_count", 8'(n_rel), 8'd4);
    for (int j = 1; j < 4; j++)
      chk("p2_spacing_ok", {7'h0, (rel_t[j] - rel_t[j-1] >= 8) && (rel_t[j] - rel_t[j-1] <= 9)}, 8'h01);
    rd_chk("p2_ctrl_end", A0, 8'h34);

    // DELAY=0: whole sequence within 8 clocks of start
    ce_period = 0;
    step(1'b0, 1'b0, 1'b1, A1, 8'h00);
    step(1'b1, 1'b0, 1'b0, A0, 8'h00);
    n = 0;
    while (!done && n < 20) begin
      step(1'b0, 1'b0, 1'b0, A0, 8'h00);
      n++;
    end
    chk("p3_latency_ok", {7'h0, n <= 8}, 8'h01);
    chk("p3_done", {7'h0, done}, 8'h01);
    chk("p3_rst_out", {4'h0, rst_out}, 8'h00);

    // HOLD after done, then restart with bit2 held the whole time
    step(1'b0, 1'b0, 1'b1, A2, 8'h04);
    chk("p4_hold_now", {4'h0, rst_out}, 8'h04);
    step(1'b0, 1'b0, 1'b1, A1, 8'h01);
    step(1'b0, 1'b0, 1'b1, A0, 8'h01);
    n = 0;
    while (!done && n < 100) begin
      step(1'b0, 1'b0, 1'b0, A0, 8'h00);
      chk("p4_bit2_held", {7'h0, rst_out[2]}, 8'h01);
      n++;
    end
    chk("p4_done", {7'h0, done}, 8'h01);
    step(1'b0, 1'b0, 1'b1, A2, 8'h00);

    // abort with simultaneous start after stage 1 released
    step(1'b1, 1'b0, 1'b0, A0, 8'h00);
    n = 0;
    while (m_k < 2 && n < 100) begin
      step(1'b0, 1'b0, 1'b0, A0, 8'h00);
      n++;
    end
    chk("p5_reached_stage1", {7'h0, m_k == 2}, {7'h0, rst_out == 4'b1100});
    step(1'b1, 1'b1, 1'b0, A0, 8'h00);
`ifndef PERIPH_RESET_SEQ_ORDERED_ABORT_EN
    chk("p5_abort_rst_out", {4'h0, rst_out}, 8'h0f);
    chk("p5_abort_busy", {7'h0, busy}, 8'h00);
    chk("p5_abort_ctrl", csr_do, 8'h00);
    repeat (3) step(1'b0, 1'b0, 1'b0, A0, 8'h00);
    chk("p5_start_ignored", {7'h0, busy}, 8'h00);
`endif
    repeat (40) step(1'b0, 1'b0, 1'b0, A0, 8'h00);

    // abort from DONE with DELAY=1
    ce_period = 4;
    step(1'b0, 1'b0, 1'b1, A1, 8'h01);
    step(1'b1, 1'b0, 1'b0, A0, 8'h00);
    run_to_done("p6_done", 100);
    step(1'b0, 1'b1, 1'b0, A0, 8'h00);
    repeat (40) step(1'b0, 1'b0, 1'b0, A0, 8'h00);
    chk("p6_final_rst_out", {4'h0, rst_out}, 8'h0f);
    chk("p6_final_busy", {7'h0, busy}, 8'h00);
    chk("p6_final_done", {7'h0, done}, 8'h00);

    // random traffic
    ce_period = 0;
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 15) == 0);
      ab = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0: ra = A0;
        1: ra = A1;
        2: ra = A2;
        3: ra = A3;
        default: ra = 5'($urandom_range(0, 31));
      endcase
      rd = (ra == A1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      step(st, ab, we, ra, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
